// File: rtl/inv_cipher_eng_if.sv
// Bus between the AES inverse cipher engine and its host.
// The host drives ciphertext and round-key words and receives plaintext.
interface inv_cipher_eng_if;
  logic        en_in;
  logic        start_in;
  logic [1:0]  conf_in;
  logic [31:0] data_in;
  logic [31:0] key_in;
  logic [3:0]  rk_round_out;
  logic [1:0]  rk_word_out;
  logic [31:0] data_out;
  logic        dvalid_out;
  logic        busy_out;

  modport master (
    output en_in, start_in, conf_in, data_in, key_in,
    input  rk_round_out, rk_word_out, data_out, dvalid_out, busy_out
  );

  modport slave (
    input  en_in, start_in, conf_in, data_in, key_in,
    output rk_round_out, rk_word_out, data_out, dvalid_out, busy_out
  );
endinterface

// File: rtl/inv_cipher_eng.sv
// Iterative AES-128/192/256 decryption engine, one state column per cycle.
// Round-key words are fetched from an external store via rk_round_out/rk_word_out.
module inv_sbox_lut (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:2047] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign y_o = TABLE[{a_i, 3'b000} +: 8];
endmodule

// state | meaning
// IDLE  | waiting for start_in; an accepted start loads column 0
// LOAD  | loading columns 1..3 xor last round key
// ROUND | inverse round r on column k; r=0 emits plaintext words
module inv_cipher_eng (
  input logic            clk_in,
  input logic            rst_in,
  inv_cipher_eng_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ROUND} state_t;

  state_t       state_q;
  logic [3:0]   nr_q, r_q;
  logic [1:0]   k_q;
  logic [127:0] cur_q, nxt_q;
  logic [31:0]  data_q;
  logic         dvalid_q;

  logic         accept;
  logic [3:0]   nr_sel;
  logic [7:0]   sb_in [4];
  logic [7:0]   sb_out [4];
  logic [31:0]  col, mix, load_col;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a, m2, m4, m8;
    logic [7:0] e [4];
    logic [7:0] b [4];
    logic [7:0] d [4];
    logic [7:0] n [4];
    for (int i = 0; i < 4; i++) begin
      a    = c[31-8*i -: 8];
      m2   = xt(a);
      m4   = xt(m2);
      m8   = xt(m4);
      e[i] = m8 ^ m4 ^ m2;
      b[i] = m8 ^ m2 ^ a;
      d[i] = m8 ^ m4 ^ a;
      n[i] = m8 ^ a;
    end
    return {e[0] ^ b[1] ^ d[2] ^ n[3], n[0] ^ e[1] ^ b[2] ^ d[3],
            d[0] ^ n[1] ^ e[2] ^ b[3], b[0] ^ d[1] ^ n[2] ^ e[3]};
  endfunction

  assign accept   = (state_q == IDLE) && bus.en_in && bus.start_in;
  assign nr_sel   = (bus.conf_in == 2'd0) ? 4'd10 : (bus.conf_in == 2'd1) ? 4'd12 : 4'd14;
  assign load_col = bus.data_in ^ bus.key_in;

  // Row j of output column k comes from column k-j (InvShiftRows).
  for (genvar j = 0; j < 4; j++) begin : g_sbox
    logic [1:0] src;
    assign src      = k_q - 2'(j);
    assign sb_in[j] = cur_q[{~src, ~2'(j), 3'b000} +: 8];
    inv_sbox_lut u_lut (.a_i(sb_in[j]), .y_o(sb_out[j]));
  end

  assign col = {sb_out[0], sb_out[1], sb_out[2], sb_out[3]} ^ bus.key_in;
  assign mix = inv_mix(col);

  // While a start is being accepted the last round key is already needed.
  always_comb begin
    bus.rk_round_out = 4'd0;
    bus.rk_word_out  = 2'd0;
    case (state_q)
      IDLE:  if (accept) bus.rk_round_out = nr_sel;
      LOAD:  begin bus.rk_round_out = nr_q; bus.rk_word_out = k_q; end
      ROUND: begin bus.rk_round_out = r_q;  bus.rk_word_out = k_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      nr_q     <= '0;
      r_q      <= '0;
      k_q      <= '0;
      cur_q    <= '0;
      nxt_q    <= '0;
      data_q   <= '0;
      dvalid_q <= 1'b0;
    end else if (!bus.en_in) begin
      dvalid_q <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          nr_q           <= nr_sel;
          cur_q[127 -: 32] <= load_col;
          k_q            <= 2'd1;
          state_q        <= LOAD;
        end
        LOAD: begin
          cur_q[{~k_q, 5'b00000} +: 32] <= load_col;
          k_q <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_q <= ROUND;
            r_q     <= nr_q - 4'd1;
          end
        end
        ROUND: begin
          k_q <= k_q + 2'd1;
          if (r_q != 4'd0) begin
            nxt_q[{~k_q, 5'b00000} +: 32] <= mix;
            if (k_q == 2'd3) begin
              cur_q <= {nxt_q[127:32], mix};
              r_q   <= r_q - 4'd1;
            end
          end else begin
            data_q   <= col;
            dvalid_q <= 1'b1;
            if (k_q == 2'd3) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.dvalid_out = dvalid_q;
  assign bus.busy_out   = (state_q != IDLE);
endmodule

// File: tb/tb_inv_cipher_eng.sv
// Directed bench for inv_cipher_eng using the FIPS-197 appendix C vectors.
// A key-schedule model answers round-key requests; a step model predicts outputs.
module tb_inv_cipher_eng;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  logic [7:0]  sb [256];
  logic [31:0] w [64];

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  inv_cipher_eng_if bus ();

  inv_cipher_eng dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.key_in = w[{bus.rk_round_out, bus.rk_word_out}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // Key bytes are 00,01,02,... as in the appendix C vectors.
  task automatic expand(input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  task automatic run(input logic [1:0] conf, input int st1, input int sl1, input int st2,
                     input int sl2, input int spur, input int s2, input int rst_at,
                     input int ncyc, input int exp_words, input int exp_last);
    logic [127:0] ct;
    logic [31:0]  exp_d;
    int nr, nk, step, nwords, last, rnd, wd;
    bit active, starting, en, exp_v, rst_prev, st;
    nk = (conf == 2'd0) ? 4 : (conf == 2'd1) ? 6 : 8;
    nr = nk + 6;
    ct = (conf == 2'd0) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
         (conf == 2'd1) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                          128'h8ea2b7ca516745bfeafc49904b496089;
    expand(nk);
    active = 0; exp_v = 0; rst_prev = 0; step = 0; nwords = 0; last = -1;
    exp_d = 32'h0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk("dvalid", 32'(bus.dvalid_out), 32'(exp_v));
      if (exp_v) begin
        chk("data", bus.data_out, exp_d);
        nwords++;
        last = c;
      end
      if (rst_prev) chk("rst_data", bus.data_out, 32'h0);
      chk("busy", 32'(bus.busy_out), 32'(active));

      en       = !((c >= st1 && c < st1 + sl1) || (c >= st2 && c < st2 + sl2));
      st       = (c == 0 || c == s2 || c == spur);
      starting = !active && en && st && (c != rst_at);
      bus.en_in    = en;
      bus.start_in = st;
      rst          = (c == rst_at);
      bus.conf_in  = (c == 0 || c == s2) ? conf : 2'($urandom);
      if (starting)                  bus.data_in = ct[127 -: 32];
      else if (active && step < 4)   bus.data_in = ct[127 - 32*step -: 32];
      else                           bus.data_in = $urandom;
      #1;
      if (active) begin
        rnd = (step < 4) ? nr : nr - 1 - (step - 4) / 4;
        wd  = step % 4;
      end else if (starting) begin
        rnd = nr; wd = 0;
      end else begin
        rnd = 0; wd = 0;
      end
      chk("rk_round", 32'(bus.rk_round_out), rnd);
      chk("rk_word", 32'(bus.rk_word_out), wd);

      exp_v    = 0;
      rst_prev = (c == rst_at);
      if (c == rst_at) begin
        active = 0;
      end else if (en) begin
        if (active) begin
          if (step >= 4*nr) begin
            exp_v = 1;
            exp_d = PT[127 - 32*(step - 4*nr) -: 32];
          end
          step++;
          if (step == 4*nr + 4) active = 0;
        end else if (starting) begin
          active = 1;
          step   = 1;
        end
      end
    end
    chk("nwords", nwords, exp_words);
    chk("last_cycle", last, exp_last);
  endtask

  initial begin
    build_sbox();
    expand(4);
    rst          = 1'b1;
    bus.en_in    = 1'b1;
    bus.start_in = 1'b0;
    bus.conf_in  = 2'd0;
    bus.data_in  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_dvalid", 32'(bus.dvalid_out), 32'h0);
    chk("rst_busy", 32'(bus.busy_out), 32'h0);
    chk("sbox_ref", 32'(sb[8'h53]), 32'h000000ed);
    rst = 1'b0;

    //  conf st1 sl1 st2 sl2 spur s2  rst ncyc words last
    run(2'd0, -1, 0, -1, 0, -1, -1, -1, 50, 4, 44);
    run(2'd1, -1, 0, -1, 0, -1, -1, -1, 58, 4, 52);
    run(2'd2, -1, 0, -1, 0, -1, -1, -1, 66, 4, 60);
    run(2'd3, -1, 0, -1, 0, -1, -1, -1, 66, 4, 60);
    run(2'd0, 20, 5, 42, 3, -1, -1, -1, 60, 4, 52);
    run(2'd0, 42, 2, -1, 0, -1, -1, -1, 55, 4, 46);
    run(2'd0, -1, 0, -1, 0, 10, 44, -1, 95, 8, 88);
    run(2'd0, -1, 0, -1, 0, -1, -1, 25, 60, 0, -1);
    run(2'd0, -1, 0, -1, 0, -1, -1, -1, 50, 4, 44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inv_cipher_eng.md
Name: inv_cipher_eng

Overview:
- Iterative AES inverse cipher (decryption) engine, the receive-side counterpart of the existing encryption engine.
- Accepts 128-bit ciphertext as four 32-bit column words and requests round-key words one per cycle from an external round-key store (standard FIPS-197 schedule, no equivalent-inverse transform).
- Processes one state column per cycle and streams the plaintext as four 32-bit words.
- Supports AES-128/192/256, selected by conf_in.

Parameters:
- None. Round counts are fixed by conf_in: Nr = 10/12/14.

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  reset, synchronous, active-high
- en_in  input  1  global enable; 0 freezes all state
- start_in  input  1  pulse carrying ciphertext word 0; accepted only in IDLE with en_in=1
- conf_in  input  2  key size: 0=128, 1=192, 2=256, 3=treated as 256; sampled at accepted start
- data_in  input  32  ciphertext word; column i, bits[31:24]=row0 ... [7:0]=row3
- key_in  input  32  round-key word addressed by rk_round_out/rk_word_out, valid combinationally in the same cycle
- rk_round_out  output  4  round-key index requested (combinational from state)
- rk_word_out  output  2  word (column) index within round key (combinational)
- data_out  output  32  plaintext word, registered
- dvalid_out  output  1  data_out valid, registered, one pulse per word
- busy_out  output  1  high whenever state != IDLE

Behaviour:
- Reset: on the edge with rst_in=1, go to IDLE and clear all registers. data_out=0, dvalid_out=0, busy_out=0. Reset wins over en_in and start_in. Reset mid-operation aborts the block; no partial output follows.
- en_in=0: no register changes, except dvalid_out, which is cleared to 0 on that edge. data_out holds its value. A resumed operation continues exactly where it stopped.
- FSM states: IDLE, LOAD, ROUND. Internal registers: round counter r (4b), column counter k (2b), 128-bit state registers cur and nxt.
- IDLE: rk_round_out=0, rk_word_out=0. An accepted start_in latches Nr from conf_in and consumes data_in as column 0 (the LOAD computation is applied in this same cycle). Next state is LOAD with k=1.
  - Start cycle = cycle 0.
- LOAD (cycles 0..3, with cycle 0 occurring in IDLE): rk_round_out=Nr, rk_word_out=k. Compute cur.col[k] = data_in ^ key_in. After k=3, go to ROUND with r=Nr-1, k=0.
  - data_in must present column k on cycles 1..3.
- ROUND cycle (r,k): rk_round_out=r, rk_word_out=k.
  - For each row j: b_j = InvSBox(cur[j][(k-j) mod 4]). This is InvShiftRows (row j rotated right by j) followed by InvSubBytes.
  - col = {b0,b1,b2,b3} ^ key_in.
  - If r>0: nxt.col[k] = InvMixColumns(col), with coefficients 0e/0b/0d/09 over GF(2^8) using polynomial 0x11b.
  - At k=3: cur <= nxt, with column 3 taking this cycle's result. Then r decrements and k wraps to 0.
  - If r=0 (final round, InvMixColumns skipped): data_out <= col and dvalid_out <= 1 on this edge.
  - At r=0,k=3: return to IDLE on the same edge.
- Inverse S-box: implemented as 4 combinational instances of a shared inv_sbox_lut submodule.
- Latency: dvalid_out is high on cycles 4Nr+1 .. 4Nr+4, giving words 0..3 in order.
  - Nr=10: cycles 41-44. Nr=12: cycles 49-52. Nr=14: cycles 57-60.
- Back-to-back: the engine is already in IDLE during cycle 4Nr+4, so a new start_in is accepted in that cycle. No bubble is required.
- start_in while busy: ignored, with no effect on the computation.
- conf_in changes while busy: ignored, because Nr is latched.
- dvalid_out is 0 in every cycle not listed above.

Test Plan:
- AES-128 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d8 6a7b0430 d8cdb780 70b4c55a, conf_in=0, bench key model answers rk requests.
  -> rk_round_out=10 with word 0 in cycle 0 (key d014f9a8). dvalid on cycles 41-44 with 00112233 44556677 8899aabb ccddeeff. busy_out falls in cycle 44.
- AES-192 (C.2): key 00..17, ciphertext dda97ca4 864cdfe0 6eaf70a0 ec0d7191, conf_in=1.
  -> same plaintext on cycles 49-52.
- AES-256 (C.3): key 00..1f, ciphertext 8ea2b7ca 516745bf eafc4990 4b496089, conf_in=2. Repeat with conf_in=3.
  -> same plaintext on cycles 57-60 in both cases.
- Stall: run the C.1 vector and deassert en_in for 5 cycles at cycle 20 and for 3 cycles at cycle 42.
  -> correct plaintext, each word pulsed exactly once, final word delayed by 8 cycles in total, dvalid_out=0 during stalls.
- Back-to-back plus ignored start: assert start_in at cycle 10 during a C.1 run.
  -> no effect. Then start a second C.1 block in cycle 44.
  -> second plaintext on cycles 85-88.
- Reset mid-operation: assert rst_in at cycle 25.
  -> next cycle data_out=0, dvalid_out=0, busy_out=0, and no dvalid pulses follow. A subsequent C.1 run decrypts correctly.
